pacman_motion_ctrl: RTL

- Upstream stage of the moving-object sprite generator: owns Pac-Man's position and facing direction.
- On each movement tick, consults the maze tile map over a req/ack handshake, decides turn/continue/stop, and steps the sprite one pixel.
- Drives pacman_x/pacman_y (sprite top-left, pixel units) and one-hot pacman_dir straight into the sprite generator.

---
 rtl/pacman_motion_ctrl.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/pacman_motion_ctrl.sv
// Pac-Man position/direction owner: per-tick maze lookups over a req/ack port, one-pixel steps.
// Optional macro CORNER_BUFFER_EN holds a pressed direction until the next aligned tile takes it.
module pacman_motion_ctrl #(
  parameter int          MAZE_TILES_X = 40,
  parameter int          MAZE_TILES_Y = 30,
  parameter logic [9:0]  START_X      = 10'd304,
  parameter logic [8:0]  START_Y      = 9'd368,
  parameter logic [3:0]  START_DIR    = 4'b0010
) (
  input  logic        clk_100mhz,
  input  logic        rst_n,
  input  logic        move_tick,
  input  logic        respawn,
  input  logic [3:0]  joy_dir,
  output logic        map_req,
  output logic [5:0]  map_tile_x,
  output logic [4:0]  map_tile_y,
  input  logic        map_ack,
  input  logic        map_wall,
  output logic [9:0]  pacman_x,
  output logic [8:0]  pacman_y,
  output logic [3:0]  pacman_dir,
  output logic        moving,
  output logic        tick_overrun
);

  localparam logic [3:0] DIR_R = 4'b0001;
  localparam logic [3:0] DIR_L = 4'b0010;
  localparam logic [3:0] DIR_U = 4'b0100;
  localparam logic [3:0] DIR_D = 4'b1000;
  localparam logic [5:0] TX_LAST = 6'(MAZE_TILES_X - 1);
  localparam logic [4:0] TY_LAST = 5'(MAZE_TILES_Y - 1);
  localparam logic [9:0] X_MAX   = 10'(MAZE_TILES_X * 16 - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ_CHK, S_REQ_WAIT, S_CUR_CHK, S_CUR_WAIT, S_STEP
  } state_t;

  state_t      r_state;
  logic [9:0]  r_x;
  logic [8:0]  r_y;
  logic [3:0]  r_dir;
  logic [3:0]  r_req;
  logic [3:0]  r_step_dir;
  logic        r_moving;
  logic        r_map_req;
  logic [5:0]  r_tile_x;
  logic [4:0]  r_tile_y;
  logic        r_pending;
  logic        r_overrun;
`ifdef CORNER_BUFFER_EN
  logic [3:0]  r_buf;
`endif

  logic        w_joy_valid;
  logic        w_aligned;
  logic        w_start;
  logic [3:0]  w_req;
  logic [11:0] w_nb_req;
  logic [11:0] w_nb_cur;

  function automatic logic f_one_hot(input logic [3:0] d);
    return (d == DIR_R) || (d == DIR_L) || (d == DIR_U) || (d == DIR_D);
  endfunction

  function automatic logic [3:0] f_opposite(input logic [3:0] d);
    logic [3:0] o;
    case (d)
      DIR_R:   o = DIR_L;
      DIR_L:   o = DIR_R;
      DIR_U:   o = DIR_D;
      DIR_D:   o = DIR_U;
      default: o = 4'b0000;
    endcase
    return o;
  endfunction

  // Returns {off_map_row, tile_x, tile_y}; rows beyond the maze are walls and never queried.
  function automatic logic [11:0] f_neighbour(input logic [3:0] d, input logic [5:0] tx,
                                              input logic [4:0] ty);
    logic [5:0] nx;
    logic [4:0] ny;
    logic       oob;
    nx  = tx;
    ny  = ty;
    oob = 1'b0;
    case (d)
      DIR_R:   nx = (tx >= TX_LAST) ? 6'd0 : tx + 6'd1;
      DIR_L:   nx = (tx == 6'd0) ? TX_LAST : tx - 6'd1;
      DIR_U:   if (ty == 5'd0) oob = 1'b1; else ny = ty - 5'd1;
      DIR_D:   if (ty >= TY_LAST) oob = 1'b1; else ny = ty + 5'd1;
      default: oob = 1'b1;
    endcase
    return {oob, nx, ny};
  endfunction

  function automatic logic [9:0] f_step_x(input logic [3:0] d, input logic [9:0] x);
    logic [9:0] nx;
    case (d)
      DIR_R:   nx = (x >= X_MAX) ? 10'd0 : x + 10'd1;
      DIR_L:   nx = (x == 10'd0) ? X_MAX : x - 10'd1;
      default: nx = x;
    endcase
    return nx;
  endfunction

  function automatic logic [8:0] f_step_y(input logic [3:0] d, input logic [8:0] y);
    logic [8:0] ny;
    case (d)
      DIR_U:   ny = y - 9'd1;
      DIR_D:   ny = y + 9'd1;
      default: ny = y;
    endcase
    return ny;
  endfunction

  assign w_joy_valid = f_one_hot(joy_dir);
  assign w_aligned   = (r_x[3:0] == 4'd0) && (r_y[3:0] == 4'd0);
  assign w_start     = move_tick || r_pending;
  assign w_nb_req    = f_neighbour(r_req, r_x[9:4], r_y[8:4]);
  assign w_nb_cur    = f_neighbour(r_dir, r_x[9:4], r_y[8:4]);

  // Direction request seen by a tick starting this cycle.
  always_comb begin
    w_req = 4'd0;
`ifdef CORNER_BUFFER_EN
    if (w_joy_valid) w_req = joy_dir;
    else             w_req = r_buf;
`else
    if (w_joy_valid) w_req = joy_dir;
    else             w_req = 4'd0;
`endif
  end

  // Motion FSM; position and direction commit together in STEP.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_x        <= START_X;
      r_y        <= START_Y;
      r_dir      <= START_DIR;
      r_req      <= 4'd0;
      r_step_dir <= START_DIR;
      r_moving   <= 1'b0;
      r_map_req  <= 1'b0;
      r_tile_x   <= 6'd0;
      r_tile_y   <= 5'd0;
      r_pending  <= 1'b0;
      r_overrun  <= 1'b0;
`ifdef CORNER_BUFFER_EN
      r_buf      <= 4'd0;
`endif
    end else if (respawn) begin
      r_state    <= S_IDLE;
      r_x        <= START_X;
      r_y        <= START_Y;
      r_dir      <= START_DIR;
      r_step_dir <= START_DIR;
      r_moving   <= 1'b0;
      r_map_req  <= 1'b0;
      r_pending  <= 1'b0;
`ifdef CORNER_BUFFER_EN
      r_buf      <= 4'd0;
`endif
    end else begin
`ifdef CORNER_BUFFER_EN
      if (w_joy_valid) r_buf <= joy_dir;
      else if (r_state == S_STEP && r_step_dir != r_dir && r_buf == r_step_dir) r_buf <= 4'd0;
`endif
      if (move_tick && r_state != S_IDLE) begin
        if (r_pending) r_overrun <= 1'b1;
        else           r_pending <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_pending <= 1'b0;
            r_req     <= w_req;
            if (w_req != 4'd0 && w_req == f_opposite(r_dir)) begin
              r_step_dir <= w_req;
              r_state    <= S_STEP;
            end else if (w_aligned && w_req != 4'd0 && w_req != r_dir) begin
              r_state <= S_REQ_CHK;
            end else if (w_aligned) begin
              r_state <= S_CUR_CHK;
            end else begin
              r_step_dir <= r_dir;
              r_state    <= S_STEP;
            end
          end
        end
        S_REQ_CHK: begin
          if (w_nb_req[11]) begin
            r_state <= S_CUR_CHK;
          end else begin
            r_tile_x  <= w_nb_req[10:5];
            r_tile_y  <= w_nb_req[4:0];
            r_map_req <= 1'b1;
            r_state   <= S_REQ_WAIT;
          end
        end
        S_REQ_WAIT: begin
          if (map_ack) begin
            r_map_req <= 1'b0;
            if (map_wall) begin
              r_state <= S_CUR_CHK;
            end else begin
              r_step_dir <= r_req;
              r_state    <= S_STEP;
            end
          end
        end
        S_CUR_CHK: begin
          if (w_nb_cur[11]) begin
            r_moving <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_tile_x  <= w_nb_cur[10:5];
            r_tile_y  <= w_nb_cur[4:0];
            r_map_req <= 1'b1;
            r_state   <= S_CUR_WAIT;
          end
        end
        S_CUR_WAIT: begin
          if (map_ack) begin
            r_map_req <= 1'b0;
            if (map_wall) begin
              r_moving <= 1'b0;
              r_state  <= S_IDLE;
            end else begin
              r_step_dir <= r_dir;
              r_state    <= S_STEP;
            end
          end
        end
        S_STEP: begin
          r_x      <= f_step_x(r_step_dir, r_x);
          r_y      <= f_step_y(r_step_dir, r_y);
          r_dir    <= r_step_dir;
          r_moving <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: begin
          r_map_req <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign map_req      = r_map_req;
  assign map_tile_x   = r_tile_x;
  assign map_tile_y   = r_tile_y;
  assign pacman_x     = r_x;
  assign pacman_y     = r_y;
  assign pacman_dir   = r_dir;
  assign moving       = r_moving;
  assign tick_overrun = r_overrun;

endmodule
